// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional burst-length cap is enabled by defining FIFO_WR_ARB_BURST_LIMIT_EN.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // last_ptr resets to the highest index so requester 0 is searched first.
  function automatic int last_ptr_rst(input int nreq);
    return nreq - 1;
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: one-hot pick of the first valid requester
// strictly after i_last_ptr, wrapping cyclically.
module fifo_wr_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_last_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic            o_any
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  int              w_idx;
  logic [NREQ-1:0] w_rot;

  always_comb begin
    o_pick = '0;
    w_idx  = 0;
    w_rot  = '0;
    // Scan farthest-to-nearest so the nearest valid requester overwrites the rest.
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = int'(i_last_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_rot = i_valid >> w_idx;
      if (w_rot[0]) o_pick = ONE << w_idx;
    end
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ burst producers.
// Define FIFO_WR_ARB_BURST_LIMIT_EN to also end a burst after MAX_BURST words.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output state_e                dbg_state
);

  // Handshake: a word moves from requester i when req_valid[i] && req_ready[i];
  // only the owner sees ready, and ready drops combinationally with wfull.

  localparam int            PW           = $clog2(NREQ);
  localparam logic [PW-1:0] LAST_PTR_RST = PW'(last_ptr_rst(NREQ));

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 2 || (MAX_BURST & (MAX_BURST - 1)) != 0) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported NREQ or MAX_BURST");
  end

  state_e          r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_last_ptr;

  logic [NREQ-1:0] w_pick;
  logic            w_any;
  logic [PW-1:0]   w_owner_idx;
  logic            w_xfer;
  logic            w_own_last;
  logic            w_limit;
  logic            w_end;

  fifo_wr_arb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_valid    (req_valid),
    .i_last_ptr (r_last_ptr),
    .o_pick     (w_pick),
    .o_any      (w_any)
  );

  assign busy       = (r_state == ST_BURST);
  assign w_xfer     = busy && (|(req_valid & r_grant)) && !wfull;
  assign w_own_last = |(req_last & r_grant);
  assign w_end      = w_xfer && (w_own_last || w_limit);

  assign winc      = w_xfer;
  assign grant     = r_grant;
  assign req_ready = r_grant & {NREQ{~wfull}};
  assign dbg_state = r_state;

  always_comb begin
    w_owner_idx = '0;
    wdata       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_owner_idx = PW'(i);
        wdata       = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_last_ptr <= LAST_PTR_RST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BURST;
            r_grant <= w_pick;
          end
        end
        ST_BURST: begin
          if (w_end) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_last_ptr <= w_owner_idx;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
  localparam int CW = cnt_width(MAX_BURST);

  logic [CW-1:0] r_cnt;

  // Counts words already moved in this burst; the MAX_BURST-th word closes it.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_limit = (r_cnt == CW'(MAX_BURST - 1));
`else
  assign w_limit = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against
// a packet-level reference model; honours FIFO_WR_ARB_BURST_LIMIT_EN.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 8;
  localparam int DEPTH     = 256;
`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [0:0]            dbg_state;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 wclk = ~wclk;

  // ---------------- sources: per-requester word queues ----------------
  logic [DSIZE:0]  src_mem [NREQ][DEPTH];
  int              head [NREQ];
  int              tail [NREQ];
  logic [NREQ-1:0] gate = '0;
  logic [NREQ-1:0] fire = '0;
  bit              rand_mode = 1'b0;
  bit              chk_en = 1'b0;
  int              rnd_pushed = 0;

  logic [DSIZE-1:0] wr_log [$];
  logic [NREQ-1:0]  gnt_log [$];
  logic [DSIZE-1:0] exp_q [$];
  logic [NREQ-1:0]  exp_g [$];
  logic [NREQ-1:0]  prev_grant = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (tail[i] != head[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_word(input int i, input logic [DSIZE-1:0] d, input bit last);
    src_mem[i][tail[i] % DEPTH] = {last, d};
    tail[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (tail[i] != head[i]) begin
        req_valid[i] = !gate[i];
        {req_last[i], req_data[i*DSIZE +: DSIZE]} = src_mem[i][head[i] % DEPTH];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DSIZE +: DSIZE] = '0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (fire[i] && head[i] != tail[i]) head[i]++;
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        gate[i] = ($urandom_range(0, 99) < 20);
        if ((tail[i] - head[i]) < 100 && $urandom_range(0, 99) < 8) begin
          int len;
          len = $urandom_range(1, 12);
          for (int w = 0; w < len; w++) push_word(i, DSIZE'($urandom), w == len - 1);
          rnd_pushed += len;
        end
      end
      wfull = ($urandom_range(0, 99) < 25);
    end
    drive();
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    rand_mode = 1'b0;
    wfull = 1'b0;
    gate = '0;
    for (int i = 0; i < NREQ; i++) head[i] = tail[i];
    drive();
    cyc();
    cyc();
    wrst_n = 1'b1;
    chk_en = 1'b1;
    drive();
    cyc();
    wr_log.delete();
    gnt_log.delete();
    exp_q.delete();
    exp_g.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(all_empty() && !busy) && n < budget) begin
      cyc();
      n++;
    end
    check({name, "_done"}, 32'(all_empty() && !busy), 32'd1);
  endtask

  task automatic compare_logs(input string name);
    check({name, "_wr_count"}, wr_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
      check({name, "_wr_word"}, wr_log[k], exp_q[k]);
    check({name, "_gnt_count"}, gnt_log.size(), exp_g.size());
    for (int k = 0; k < exp_g.size() && k < gnt_log.size(); k++)
      check({name, "_gnt_order"}, gnt_log[k], exp_g[k]);
  endtask

  // ---------------- reference model: owner / rotation pointer / burst words ----------------
  bit m_busy;
  int m_owner;
  int m_last_ptr;
  int m_cnt;

  always @(posedge wclk or negedge wrst_n) begin : model
    int sel;
    if (!wrst_n) begin
      m_busy     <= 1'b0;
      m_owner    <= 0;
      m_last_ptr <= NREQ - 1;
      m_cnt      <= 0;
    end else if (!m_busy) begin
      sel = -1;
      for (int k = 1; k <= NREQ; k++)
        if (sel < 0 && req_valid[(m_last_ptr + k) % NREQ]) sel = (m_last_ptr + k) % NREQ;
      if (sel >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= sel;
        m_cnt   <= 0;
      end
    end else if (req_valid[m_owner] && !wfull) begin
      m_cnt <= m_cnt + 1;
      if (req_last[m_owner] || (LIMIT_EN && m_cnt + 1 == MAX_BURST)) begin
        m_busy     <= 1'b0;
        m_last_ptr <= m_owner;
      end
    end
  end

  // ---------------- per-cycle compare, away from the active edge ----------------
  always @(negedge wclk) begin : compare
    logic [NREQ-1:0] eg;
    logic            ew;
    fire = req_valid & req_ready;
    if (chk_en) begin
      eg = m_busy ? (NREQ'(1) << m_owner) : '0;
      ew = m_busy && req_valid[m_owner] && !wfull;
      check("grant", grant, eg);
      check("busy", busy, m_busy);
      check("dbg_state", dbg_state, m_busy);
      check("winc", winc, ew);
      check("req_ready", req_ready, wfull ? '0 : eg);
      if (ew) check("wdata", wdata, src_mem[m_owner][head[m_owner] % DEPTH][DSIZE-1:0]);
      if (winc) wr_log.push_back(wdata);
      if (grant != '0 && prev_grant == '0) gnt_log.push_back(grant);
      prev_grant = grant;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    wrst_n = 1'b0;
    wfull = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;

    // Reset values while reset is held, then after release
    drive();
    cyc();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_winc", winc, 0);
    check("rst_ready", req_ready, 0);
    do_reset();
    check("post_rst_grant", grant, 0);

    // T1: requester 2, 3-word burst
    push_word(2, 8'h11, 0);
    push_word(2, 8'h22, 0);
    push_word(2, 8'h33, 1);
    drive();
    cyc();
    check("t1_grant_latency", grant, 4'b0100);
    wait_idle("t1", 20);
    check("t1_grant_after", grant, 0);
    exp_q = '{8'h11, 8'h22, 8'h33};
    exp_g = '{4'b0100};
    compare_logs("t1");

    // T2: all requesters valid with 2-word bursts
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      push_word(i, DSIZE'(i * 16), 0);
      push_word(i, DSIZE'(i * 16 + 1), 1);
    end
    push_word(0, 8'h02, 0);
    push_word(0, 8'h03, 1);
    drive();
    wait_idle("t2", 60);
    exp_q = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    compare_logs("t2");

    // T3: wfull held high 5 cycles mid-burst of requester 1
    do_reset();
    for (int w = 0; w < 4; w++) push_word(1, DSIZE'(8'hA0 + w), w == 3);
    drive();
    n = 0;
    while (wr_log.size() < 2 && n < 20) begin
      cyc();
      n++;
    end
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_winc_full", winc, 0);
      check("t3_ready_full", req_ready, 0);
      cyc();
    end
    wfull = 1'b0;
    #1;
    check("t3_winc_resume", winc, 1);
    wait_idle("t3", 20);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    exp_g = '{4'b0010};
    compare_logs("t3");

    // T4: owner drops valid for 2 cycles while requester 3 waits
    do_reset();
    push_word(0, 8'h40, 0);
    push_word(0, 8'h41, 0);
    push_word(0, 8'h42, 1);
    push_word(3, 8'h70, 1);
    drive();
    n = 0;
    while (wr_log.size() < 1 && n < 20) begin
      cyc();
      n++;
    end
    gate[0] = 1'b1;
    drive();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4_grant_held", grant, 4'b0001);
      check("t4_winc_gap", winc, 0);
      cyc();
    end
    gate[0] = 1'b0;
    drive();
    wait_idle("t4", 20);
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h70};
    exp_g = '{4'b0001, 4'b1000};
    compare_logs("t4");

    // T5: 12-word packet from 0 while 1 is valid
    do_reset();
    for (int w = 0; w < 12; w++) push_word(0, DSIZE'(w), w == 11);
    push_word(1, 8'h50, 0);
    push_word(1, 8'h51, 1);
    drive();
    wait_idle("t5", 60);
    if (LIMIT_EN) begin
      exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h50, 8'h51, 8'h08, 8'h09, 8'h0A, 8'h0B};
      exp_g = '{4'b0001, 4'b0010, 4'b0001};
    end else begin
      exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'h0A, 8'h0B, 8'h50, 8'h51};
      exp_g = '{4'b0001, 4'b0010};
    end
    compare_logs("t5");

    // T6: reset on the 2nd word, then 0 beats simultaneously valid 3
    do_reset();
    push_word(0, 8'h80, 0);
    push_word(0, 8'h81, 0);
    push_word(0, 8'h82, 1);
    drive();
    n = 0;
    while (wr_log.size() < 1 && n < 20) begin
      cyc();
      n++;
    end
    wrst_n = 1'b0;
    #1;
    check("t6_grant_rst", grant, 0);
    check("t6_winc_rst", winc, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_ready_rst", req_ready, 0);
    do_reset();
    push_word(3, 8'h93, 1);
    push_word(0, 8'h90, 1);
    drive();
    wait_idle("t6", 20);
    exp_q = '{8'h90, 8'h93};
    exp_g = '{4'b0001, 4'b1000};
    compare_logs("t6");

    // Randomized traffic with random gating and wfull
    do_reset();
    rnd_pushed = 0;
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) cyc();
    rand_mode = 1'b0;
    gate = '0;
    wfull = 1'b0;
    drive();
    wait_idle("rnd", 3000);
    check("rnd_word_count", wr_log.size(), rnd_pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
